// File: rtl/wb_mailbox_pkg.sv
// Shared constants for the wb_mailbox register map, STATUS layout and INT_EN bits.
package wb_mailbox_pkg;
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_INT_EN = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_EMPTY   = 2;
  localparam int ST_RX_FULL    = 3;
  localparam int ST_TX_OVF     = 4;
  localparam int ST_RX_UNF     = 5;
  localparam int ST_TX_CNT_LSB = 8;
  localparam int ST_RX_CNT_LSB = 16;

  localparam int IE_RX_NONEMPTY = 0;
  localparam int IE_TX_EMPTY    = 1;
endpackage

// File: rtl/wb_mailbox_if.sv
// Wishbone classic bus bundle for the mailbox; master drives requests, slave acks.
interface wb_mailbox_if #(parameter int ADDR_WIDTH = 6);
  logic [ADDR_WIDTH-1:0] adr_i;
  logic [31:0]           dat_i;
  logic [31:0]           dat_o;
  logic                  we_i;
  logic [3:0]            sel_i;
  logic                  stb_i;
  logic                  cyc_i;
  logic                  ack_o;

  modport master (output adr_i, dat_i, we_i, sel_i, stb_i, cyc_i, input dat_o, ack_o);
  modport slave  (input adr_i, dat_i, we_i, sel_i, stb_i, cyc_i, output dat_o, ack_o);
endinterface

// File: rtl/mbox_fifo.sv
// Registered-count FIFO, no fall-through. Flush beats push/pop; a pop frees the slot
// for a same-edge push when full.
module mbox_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DEPTH_C);
  assign count   = cnt_q;
  assign dout    = mem_q[rptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wptr_d = wptr_q + DEPTH_LOG2'(do_push);
    rptr_d = rptr_q + DEPTH_LOG2'(do_pop);
    cnt_d  = cnt_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is not reset; the count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q] <= din;
  end
endmodule

// File: rtl/wb_mailbox.sv
// Wishbone mailbox: TX FIFO (EC -> CPU side) and RX FIFO (CPU side -> EC) with status,
// sticky errors and flush. Define WB_MAILBOX_IRQ_EN to build INT_EN and the irq output.
module wb_mailbox
  import wb_mailbox_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  wb_mailbox_if.slave wb,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
  logic [1:0]  int_en;
  logic [1:0]  idx;
  logic        req, wr, rd;
  logic        tx_push, tx_pop, tx_flush, tx_empty, tx_full;
  logic        rx_push, rx_pop, rx_flush, rx_empty, rx_full;
  logic        data_rd, status_wr, ctrl_wr;
  logic [DEPTH_LOG2:0] tx_cnt, rx_cnt;
  logic [31:0] rx_head, rdata;
  logic        unused_adr;

  assign idx        = wb.adr_i[3:2];
  assign unused_adr = ^{wb.adr_i[ADDR_WIDTH-1:4], wb.adr_i[1:0]};

  // Every side effect is qualified by req, so it lands on the edge that raises ack.
  assign req       = wb.stb_i & wb.cyc_i & ~ack_q;
  assign wr        = req & wb.we_i;
  assign rd        = req & ~wb.we_i;
  assign data_rd   = rd & (idx == REG_DATA);
  assign status_wr = wr & (idx == REG_STATUS) & wb.sel_i[0];
  assign ctrl_wr   = wr & (idx == REG_CTRL);

  assign tx_push  = wr & (idx == REG_DATA) & (wb.sel_i == 4'hF);
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_flush = ctrl_wr & wb.dat_i[0];
  assign tx_valid = ~tx_empty;

  // Ready stays up while full if the bus pops on this edge, so the slot is reused.
  assign rx_pop   = data_rd & ~rx_empty;
  assign rx_ready = ~rx_full | rx_pop;
  assign rx_push  = rx_valid & rx_ready;
  assign rx_flush = ctrl_wr & wb.dat_i[1];

  mbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(32)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .din(wb.dat_i), .dout(tx_data), .empty(tx_empty), .full(tx_full), .count(tx_cnt)
  );

  mbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(32)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
    .din(rx_data), .dout(rx_head), .empty(rx_empty), .full(rx_full), .count(rx_cnt)
  );

  always_comb begin
    tx_ovf_d = tx_ovf_q | (tx_push & tx_full & ~tx_pop);
    rx_unf_d = rx_unf_q | (data_rd & rx_empty);
    if (status_wr && wb.dat_i[ST_TX_OVF]) tx_ovf_d = 1'b0;
    if (status_wr && wb.dat_i[ST_RX_UNF]) rx_unf_d = 1'b0;
  end

  always_comb begin
    rdata = '0;
    unique case (idx)
      REG_DATA:   rdata = rx_empty ? 32'h0 : rx_head;
      REG_STATUS: begin
        rdata[ST_TX_FULL]  = tx_full;
        rdata[ST_TX_EMPTY] = tx_empty;
        rdata[ST_RX_EMPTY] = rx_empty;
        rdata[ST_RX_FULL]  = rx_full;
        rdata[ST_TX_OVF]   = tx_ovf_q;
        rdata[ST_RX_UNF]   = rx_unf_q;
        rdata[ST_TX_CNT_LSB +: 8] = 8'(tx_cnt);
        rdata[ST_RX_CNT_LSB +: 8] = 8'(rx_cnt);
      end
      REG_INT_EN: rdata[1:0] = int_en;
      default:    rdata = '0;
    endcase
  end

  assign ack_d = req;
  assign dat_d = rd ? rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
    end
  end

  assign wb.ack_o = ack_q;
  assign wb.dat_o = dat_q;

`ifdef WB_MAILBOX_IRQ_EN
  logic [1:0] int_en_q, int_en_d;
  logic       irq_q, irq_d;

  assign int_en_d = (wr && idx == REG_INT_EN && wb.sel_i[0]) ? wb.dat_i[1:0] : int_en_q;
  assign irq_d    = (int_en_q[IE_RX_NONEMPTY] & ~rx_empty) | (int_en_q[IE_TX_EMPTY] & tx_empty);

  always_ff @(posedge clk) begin
    if (reset) begin
      int_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      int_en_q <= int_en_d;
      irq_q    <= irq_d;
    end
  end

  assign int_en = int_en_q;
  assign irq    = irq_q;
`else
  assign int_en = 2'b00;
  assign irq    = 1'b0;
`endif
endmodule

// File: tb/tb_wb_mailbox.sv
// Directed checks of wb_mailbox: handshake, TX/RX FIFOs, sticky flags, flush and irq.
module tb_wb_mailbox;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;
  int          n_chk = 0, n_fail = 0;

  wb_mailbox_if #(.ADDR_WIDTH(6)) bus ();

  wb_mailbox #(.ADDR_WIDTH(6), .DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(reset), .wb(bus),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  // Single bus transfer; returns read data and cycles from request to ack.
  task automatic wb_xfer(input logic we, input logic [5:0] adr, input logic [31:0] d,
                         input logic [3:0] sel, output logic [31:0] rd, output int lat);
    @(negedge clk);
    bus.adr_i = adr; bus.dat_i = d; bus.we_i = we; bus.sel_i = sel;
    bus.stb_i = 1'b1; bus.cyc_i = 1'b1;
    lat = 0;
    rd  = '0;
    while (lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (bus.ack_o === 1'b1) break;
    end
    if (bus.ack_o !== 1'b1) begin
      $display("FAIL wb_timeout adr=%0h got no ack, need ack", adr);
      n_fail++; n_chk++;
    end
    rd = bus.dat_o;
    bus.stb_i = 1'b0; bus.cyc_i = 1'b0; bus.we_i = 1'b0;
  endtask

  task automatic pulse_rx(input logic [31:0] d);
    @(negedge clk);
    rx_data = d; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    if ({bus.ack_o, tx_valid, rx_ready, irq} !== 4'b0010) begin
      $display("FAIL reset_outs got %b need 0010", {bus.ack_o, tx_valid, rx_ready, irq}); n_fail++;
    end
    n_chk++;
    if (bus.dat_o !== 32'h0) begin $display("FAIL reset_dat got %h need 0", bus.dat_o); n_fail++; end
    n_chk++;
    wb_xfer(1'b0, 6'h04, 32'h0, 4'hF, rd, lat);
    if (rd !== 32'h6) begin $display("FAIL reset_status got %h need 00000006", rd); n_fail++; end
    n_chk++;
    if (lat != 1) begin $display("FAIL ack_latency got %0d need 1", lat); n_fail++; end
    n_chk++;
    @(posedge clk); #1;
    if ({bus.ack_o, bus.dat_o} !== 33'h0) begin
      $display("FAIL ack_one_cycle got ack=%b dat=%h need 0/0", bus.ack_o, bus.dat_o); n_fail++;
    end
    n_chk++;
  endtask

  task automatic test_tx_single();
    logic [31:0] rd; int lat;
    tx_ready = 1'b0;
    wb_xfer(1'b1, 6'h00, 32'h1111_2222, 4'h3, rd, lat);
    if (tx_valid !== 1'b0) begin $display("FAIL partial_sel got tx_valid=%b need 0", tx_valid); n_fail++; end
    n_chk++;
    wb_xfer(1'b1, 6'h00, 32'hDEAD_BEEF, 4'hF, rd, lat);
    if ({tx_valid, tx_data} !== {1'b1, 32'hDEAD_BEEF}) begin
      $display("FAIL tx_push got v=%b d=%h need 1/deadbeef", tx_valid, tx_data); n_fail++;
    end
    n_chk++;
    wb_xfer(1'b0, 6'h04, 32'h0, 4'hF, rd, lat);
    if (rd !== 32'h0000_0104) begin $display("FAIL tx_status1 got %h need 00000104", rd); n_fail++; end
    n_chk++;
    @(negedge clk) tx_ready = 1'b1;
    @(posedge clk); #1 tx_ready = 1'b0;
    if (tx_valid !== 1'b0) begin $display("FAIL tx_pop got tx_valid=%b need 0", tx_valid); n_fail++; end
    n_chk++;
    wb_xfer(1'b0, 6'h04, 32'h0, 4'hF, rd, lat);
    if (rd !== 32'h6) begin $display("FAIL tx_status0 got %h need 00000006", rd); n_fail++; end
    n_chk++;
  endtask

  task automatic test_tx_fill();
    logic [31:0] rd; int lat; int bad;
    for (int i = 1; i <= 17; i++) wb_xfer(1'b1, 6'h00, 32'(i), 4'hF, rd, lat);
    wb_xfer(1'b0, 6'h04, 32'h0, 4'hF, rd, lat);
    if (rd !== 32'h0000_1015) begin $display("FAIL tx_full_status got %h need 00001015", rd); n_fail++; end
    n_chk++;
    wb_xfer(1'b1, 6'h04, 32'h10, 4'hF, rd, lat);
    wb_xfer(1'b0, 6'h04, 32'h0, 4'hF, rd, lat);
    if (rd !== 32'h0000_1005) begin $display("FAIL tx_ovf_w1c got %h need 00001005", rd); n_fail++; end
    n_chk++;
    bad = 0;
    for (int i = 1; i <= 16; i++) begin
      if ({tx_valid, tx_data} !== {1'b1, 32'(i)}) begin
        $display("FAIL tx_order got v=%b d=%h need 1/%h", tx_valid, tx_data, 32'(i)); bad++;
      end
      n_chk++;
      @(negedge clk) tx_ready = 1'b1;
      @(posedge clk); #1 tx_ready = 1'b0;
    end
    n_fail += bad;
    if (tx_valid !== 1'b0) begin $display("FAIL tx_drained got %b need 0", tx_valid); n_fail++; end
    n_chk++;
  endtask

  task automatic test_rx();
    logic [31:0] rd; int lat;
    pulse_rx(32'h1234_5678);
    wb_xfer(1'b0, 6'h00, 32'h0, 4'hF, rd, lat);
    if (rd !== 32'h1234_5678) begin $display("FAIL rx_read got %h need 12345678", rd); n_fail++; end
    n_chk++;
    wb_xfer(1'b0, 6'h00, 32'h0, 4'hF, rd, lat);
    if (rd !== 32'h0) begin $display("FAIL rx_empty_read got %h need 0", rd); n_fail++; end
    n_chk++;
    wb_xfer(1'b0, 6'h04, 32'h0, 4'hF, rd, lat);
    if (rd !== 32'h26) begin $display("FAIL rx_unf_status got %h need 00000026", rd); n_fail++; end
    n_chk++;
    wb_xfer(1'b1, 6'h04, 32'h20, 4'h1, rd, lat);
    wb_xfer(1'b0, 6'h04, 32'h0, 4'hF, rd, lat);
    if (rd !== 32'h6) begin $display("FAIL rx_unf_w1c got %h need 00000006", rd); n_fail++; end
    n_chk++;
  endtask

  task automatic test_rx_full();
    logic [31:0] rd; int lat;
    for (int i = 0; i < 16; i++) pulse_rx(32'h100 + 32'(i));
    if (rx_ready !== 1'b0) begin $display("FAIL rx_ready_full got %b need 0", rx_ready); n_fail++; end
    n_chk++;
    wb_xfer(1'b0, 6'h04, 32'h0, 4'hF, rd, lat);
    if (rd !== 32'h0010_000A) begin $display("FAIL rx_full_status got %h need 0010000a", rd); n_fail++; end
    n_chk++;
    @(negedge clk);
    rx_data = 32'hAAAA_0001; rx_valid = 1'b1;
    wb_xfer(1'b0, 6'h00, 32'h0, 4'hF, rd, lat);
    rx_valid = 1'b0;
    if (rd !== 32'h100) begin $display("FAIL rx_full_pop got %h need 00000100", rd); n_fail++; end
    n_chk++;
    wb_xfer(1'b0, 6'h04, 32'h0, 4'hF, rd, lat);
    if (rd !== 32'h0010_000A) begin $display("FAIL rx_push_pop_full got %h need 0010000a", rd); n_fail++; end
    n_chk++;
    wb_xfer(1'b1, 6'h0C, 32'h2, 4'hF, rd, lat);
    wb_xfer(1'b0, 6'h04, 32'h0, 4'hF, rd, lat);
    if (rd !== 32'h6) begin $display("FAIL rx_flush got %h need 00000006", rd); n_fail++; end
    n_chk++;
    if (rx_ready !== 1'b1) begin $display("FAIL rx_ready_flush got %b need 1", rx_ready); n_fail++; end
    n_chk++;
    wb_xfer(1'b0, 6'h0C, 32'h0, 4'hF, rd, lat);
    if (rd !== 32'h0) begin $display("FAIL ctrl_read got %h need 0", rd); n_fail++; end
    n_chk++;
  endtask

  task automatic test_irq();
    logic [31:0] rd; int lat;
`ifdef WB_MAILBOX_IRQ_EN
    wb_xfer(1'b1, 6'h08, 32'h1, 4'hF, rd, lat);
    wb_xfer(1'b0, 6'h08, 32'h0, 4'hF, rd, lat);
    if (rd !== 32'h1) begin $display("FAIL int_en_read got %h need 1", rd); n_fail++; end
    n_chk++;
    pulse_rx(32'h55);
    if (irq !== 1'b0) begin $display("FAIL irq_lag got %b need 0", irq); n_fail++; end
    n_chk++;
    @(posedge clk); #1;
    if (irq !== 1'b1) begin $display("FAIL irq_set got %b need 1", irq); n_fail++; end
    n_chk++;
    wb_xfer(1'b0, 6'h00, 32'h0, 4'hF, rd, lat);
    @(posedge clk); #1;
    if (irq !== 1'b0) begin $display("FAIL irq_clear got %b need 0", irq); n_fail++; end
    n_chk++;
    wb_xfer(1'b1, 6'h08, 32'h0, 4'hF, rd, lat);
`else
    wb_xfer(1'b1, 6'h08, 32'h3, 4'hF, rd, lat);
    wb_xfer(1'b0, 6'h08, 32'h0, 4'hF, rd, lat);
    if (rd !== 32'h0) begin $display("FAIL int_en_absent got %h need 0", rd); n_fail++; end
    n_chk++;
    pulse_rx(32'h55);
    @(posedge clk); #1;
    if (irq !== 1'b0) begin $display("FAIL irq_tied got %b need 0", irq); n_fail++; end
    n_chk++;
    wb_xfer(1'b0, 6'h00, 32'h0, 4'hF, rd, lat);
    if (rd !== 32'h55) begin $display("FAIL irq_pop got %h need 00000055", rd); n_fail++; end
    n_chk++;
`endif
  endtask

  initial begin
    bus.adr_i = '0; bus.dat_i = '0; bus.we_i = 1'b0; bus.sel_i = '0;
    bus.stb_i = 1'b0; bus.cyc_i = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    test_reset();
    test_tx_single();
    test_tx_fill();
    test_rx();
    test_rx_full();
    test_irq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_mailbox.md
Name: wb_mailbox

Overview:
- Wishbone classic slave sitting directly downstream of limb_interface, on the same bus segment as wb_ram.
- Provides two 32-bit FIFOs between the EC/LIMB side and the CPU-side logic:
  - TX: the EC writes words that the CPU side consumes.
  - RX: the CPU side produces words that the EC reads.
- Status, sticky error flags and flush control are exposed as Wishbone registers; an optional interrupt flags pending traffic.

Parameters:
- ADDR_WIDTH, 6, byte-address width of adr_i; word index = adr_i[3:2], higher bits ignored.
- DEPTH_LOG2, 4, log2 of each FIFO depth (16 words); legal range 1..7.

Ports:
- clk  input  1  single clock (Wishbone and CPU side)
- reset  input  1  synchronous, active-high reset
- adr_i  input  ADDR_WIDTH  Wishbone byte address
- dat_i  input  32  Wishbone write data
- dat_o  output  32  Wishbone read data
- we_i  input  1  Wishbone write enable
- sel_i  input  4  Wishbone byte selects
- stb_i  input  1  Wishbone strobe
- cyc_i  input  1  Wishbone cycle
- ack_o  output  1  Wishbone acknowledge
- tx_data  output  32  head word of TX FIFO
- tx_valid  output  1  TX FIFO non-empty
- tx_ready  input  1  CPU side consumes tx_data when tx_valid & tx_ready
- rx_data  input  32  word offered by CPU side
- rx_valid  input  1  CPU side offers rx_data
- rx_ready  output  1  RX FIFO not full
- irq  output  1  interrupt, active-high

Behaviour:
- Reset (sync, active-high): both FIFOs empty, pointers/counts 0, sticky flags 0, INT_EN 0. Outputs: ack_o=0, dat_o=0, tx_valid=0, rx_ready=1, irq=0. A bus cycle in flight at reset is dropped with no ack.
- Wishbone handshake:
  - A request is stb_i & cyc_i & !ack_o.
  - ack_o is registered, asserts 1 cycle after the request, and holds for exactly 1 cycle. Back-to-back requests therefore ack on every other cycle.
  - dat_o is valid only while ack_o=1 and is 0 otherwise.
  - All side effects (push, pop, W1C, flush) occur on the clock edge that asserts ack_o.
- Register map (word index):
  - 0 DATA:
    - Write pushes dat_i to TX only when sel_i=4'hF; partial sel is acked and ignored.
    - Write when TX full: word dropped, TX_OVF set.
    - Read pops the RX head into dat_o. Read when RX empty returns 0, no pop, RX_UNF set.
  - 1 STATUS (read):
    - [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full, [4] TX_OVF, [5] RX_UNF.
    - [15:8] tx count, [23:16] rx count (zero-extended, width DEPTH_LOG2+1).
    - Other bits 0.
    - Write: W1C on bits 4/5 when sel_i[0]=1.
  - 2 INT_EN: bit0 = irq on rx non-empty; bit1 = irq on tx empty. R/W, sel_i[0] gates the write.
  - 3 CTRL:
    - Write bit0 flushes TX; write bit1 flushes RX. Self-clearing; reads as 0.
    - Flush empties the FIFO that same edge and overrides a simultaneous push/pop on that FIFO.
- FIFO rules, both FIFOs:
  - Registered count; no fall-through. A word pushed at edge N is visible on the output from edge N+1.
  - Simultaneous push and pop on a non-empty, non-full FIFO: both occur, count unchanged.
  - Simultaneous push and pop on a full FIFO: both occur (the pop frees the slot).
  - Push on empty with a pop attempt: only the push occurs.
  - Pointers wrap modulo 2^DEPTH_LOG2.
- CPU side:
  - TX pop when tx_valid & tx_ready. tx_data is the head word and is stable while tx_valid & !tx_ready.
  - RX push when rx_valid & rx_ready. rx_ready deasserts the cycle after the count reaches depth.

Optional Feature:
- WB_MAILBOX_IRQ_EN defined:
  - irq registered = (INT_EN[0] & !rx_empty) | (INT_EN[1] & tx_empty).
  - irq updates 1 cycle after the state change.
- Undefined:
  - irq tied 0; INT_EN is not implemented, reads 0, and writes are acked and ignored.

Decomposition:
- Package wb_mailbox_pkg holds:
  - register index constants REG_DATA=0, REG_STATUS=1, REG_INT_EN=2, REG_CTRL=3;
  - STATUS bit-position constants;
  - the INT_EN bit constants.
- One sub-module, mbox_fifo (parameter DEPTH_LOG2, width 32):
  - ports push, pop, flush, din, dout, empty, full, count;
  - instantiated twice.

Test Plan:
- Reset, then read STATUS at word 1 -> dat_o=32'h0000_0006 (tx_empty, rx_empty); ack_o exactly 1 cycle after request.
- Write DATA 32'hDEADBEEF with sel 4'hF, tx_ready=0 -> tx_valid=1 the next cycle, tx_data=DEADBEEF; STATUS[15:8]=1. Pulse tx_ready -> tx_valid=0 and count 0.
- Write 17 words with DEPTH_LOG2=4 and tx_ready=0 -> STATUS shows tx_full=1, TX_OVF=1, count 16; tx_data order is 1..16. Write STATUS 32'h10 -> TX_OVF clears.
- Drive rx_valid with 32'h1234_5678 for 1 cycle, then read DATA -> dat_o=12345678. Read DATA again -> dat_o=0 and RX_UNF=1.
- Fill RX to 16 words -> rx_ready=0. A simultaneous Wishbone DATA read and rx_valid push keep the count at 16. CTRL write 2 -> rx_empty=1 the next cycle.
- With WB_MAILBOX_IRQ_EN: INT_EN=1 and one RX push -> irq=1 one cycle later; pop -> irq=0. With the macro undefined: irq stays 0 and INT_EN reads 0.
